// File: rtl/kernel_cache_read_arbiter.sv
// Round-robin merge of NUM_CHANNELS AXI4 read requesters onto one cache read port.
// ARID carries the channel index; R beats are routed back by RID through a registered slot.
module kernel_cache_read_arbiter #(
    parameter int NUM_CHANNELS    = 4,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       ap_clk,
    input  logic                       areset_n,
    input  logic                       cache_initializing,
    output logic                       cache_setup_signal,
    input  logic [NUM_CHANNELS-1:0]    s_arvalid,
    output logic [NUM_CHANNELS-1:0]    s_arready,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] s_araddr,
    input  logic [NUM_CHANNELS*8-1:0]  s_arlen,
    output logic [NUM_CHANNELS-1:0]    s_rvalid,
    input  logic [NUM_CHANNELS-1:0]    s_rready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic                       s_rlast,
    output logic [1:0]                 s_rresp,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    output logic [ADDR_W-1:0]          m_araddr,
    output logic [7:0]                 m_arlen,
    output logic [ID_W-1:0]            m_arid,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    input  logic [DATA_W-1:0]          m_rdata,
    input  logic [ID_W-1:0]            m_rid,
    input  logic                       m_rlast,
    input  logic [1:0]                 m_rresp,
    output logic                       route_error
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {1'b0, {(ADDR_W-1){1'b1}}};

    logic                  setup_q, setup_d;
    logic                  ar_full_q, ar_full_d;
    logic [ADDR_W-1:0]     ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [ID_W-1:0]       ar_id_q, ar_id_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q [NUM_CHANNELS];
    logic [CNT_W-1:0]      cnt_d [NUM_CHANNELS];
    logic                  r_full_q, r_full_d;
    logic [CH_W-1:0]       r_ch_q, r_ch_d;
    logic [DATA_W-1:0]     r_data_q, r_data_d;
    logic                  r_last_q, r_last_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  route_err_q, route_err_d;

    logic [NUM_CHANNELS-1:0] eligible;
    logic                    found;
    logic [CH_W-1:0]         win;
    logic                    grant;
    logic                    r_pop, r_beat, rid_ok;

    // Arbitration: first eligible channel at or after the round-robin pointer.
    // NOTE: every always_comb output gets a default before any branch, so no latches are inferred.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        win      = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            eligible[c] = s_arvalid[c] && (cnt_q[c] < CNT_MAX) && !cache_initializing;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        // Reset is folded in so no requester sees a handshake while the block is held in reset.
        grant     = areset_n && found && (!ar_full_q || m_arready);
        s_arready = '0;
        if (grant) s_arready[win] = 1'b1;
    end

    always_comb begin
        setup_d   = cache_initializing;
        ar_full_d = grant || (ar_full_q && !m_arready);
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_id_d   = ar_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            ar_addr_d = s_araddr[win*ADDR_W +: ADDR_W] & ADDR_MASK;
            ar_len_d  = s_arlen[win*8 +: 8];
            ar_id_d   = ID_W'(win);
            rr_ptr_d  = (win == LAST_CH) ? '0 : win + 1'b1;
        end
    end

    // R slot: refills in the same cycle it drains; beats with an unknown RID are swallowed.
    always_comb begin
        r_pop    = r_full_q && s_rready[r_ch_q];
        m_rready = !r_full_q || s_rready[r_ch_q];
        r_beat   = m_rvalid && m_rready;
        rid_ok   = int'(m_rid) < NUM_CHANNELS;
        r_full_d = r_full_q && !r_pop;
        r_ch_d   = r_ch_q;
        r_data_d = r_data_q;
        r_last_d = r_last_q;
        r_resp_d = r_resp_q;
        if (r_beat && rid_ok) begin
            r_full_d = 1'b1;
            r_ch_d   = m_rid[CH_W-1:0];
            r_data_d = m_rdata;
            r_last_d = m_rlast;
            r_resp_d = m_rresp;
        end
        route_err_d = route_err_q || (r_beat && !rid_ok);
        s_rvalid = '0;
        if (r_full_q) s_rvalid[r_ch_q] = 1'b1;
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            logic inc, dec;
            inc      = s_arvalid[c] && s_arready[c];
            dec      = s_rvalid[c] && s_rready[c] && r_last_q;
            cnt_d[c] = cnt_q[c];
            if (inc && !dec)                        cnt_d[c] = cnt_q[c] + 1'b1;
            else if (dec && !inc && cnt_q[c] != '0) cnt_d[c] = cnt_q[c] - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            setup_q     <= 1'b1;
            ar_full_q   <= 1'b0;
            rr_ptr_q    <= '0;
            r_full_q    <= 1'b0;
            r_ch_q      <= '0;
            route_err_q <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
        end else begin
            setup_q     <= setup_d;
            ar_full_q   <= ar_full_d;
            rr_ptr_q    <= rr_ptr_d;
            r_full_q    <= r_full_d;
            r_ch_q      <= r_ch_d;
            route_err_q <= route_err_d;
            for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    // NOTE: payload registers are qualified by their valid flags, so they carry no reset.
    always_ff @(posedge ap_clk) begin
        ar_addr_q <= ar_addr_d;
        ar_len_q  <= ar_len_d;
        ar_id_q   <= ar_id_d;
        r_data_q  <= r_data_d;
        r_last_q  <= r_last_d;
        r_resp_q  <= r_resp_d;
    end

    assign cache_setup_signal = setup_q;
    assign m_arvalid          = ar_full_q;
    assign m_araddr           = ar_addr_q;
    assign m_arlen            = ar_len_q;
    assign m_arid             = ar_id_q;
    assign s_rdata            = r_data_q;
    assign s_rlast            = r_last_q;
    assign s_rresp            = r_resp_q;
    assign route_error        = route_err_q;

endmodule

// File: tb/tb_kernel_cache_read_arbiter.sv
// Scoreboarded bench for kernel_cache_read_arbiter: expected AR/R transfers are queued
// when stimulus is driven and compared when the DUT hands them over.
module tb_kernel_cache_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int IW = 4;
    localparam logic [AW-1:0] MASK63 = 64'h7FFF_FFFF_FFFF_FFFF;

    logic              ap_clk = 1'b0;
    logic              areset_n;
    logic              cache_initializing;
    logic              cache_setup_signal;
    logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0]   s_araddr;
    logic [N*8-1:0]    s_arlen;
    logic [DW-1:0]     s_rdata, m_rdata;
    logic              s_rlast, m_rlast;
    logic [1:0]        s_rresp, m_rresp;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [IW-1:0]     m_arid, m_rid;
    logic              route_error;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } ar_exp_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    resp;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int r_delivered = 0;

    kernel_cache_read_arbiter #(
        .NUM_CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTSTANDING(8)
    ) dut (
        .ap_clk(ap_clk), .areset_n(areset_n),
        .cache_initializing(cache_initializing), .cache_setup_signal(cache_setup_signal),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rlast(m_rlast), .m_rresp(m_rresp),
        .route_error(route_error)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void push_ar(input int c);
        ar_exp_t e;
        e.addr = s_araddr[c*AW +: AW] & MASK63;
        e.len  = s_arlen[c*8 +: 8];
        e.id   = IW'(c);
        ar_q.push_back(e);
    endfunction

    function automatic void push_r(input int c);
        r_exp_t e;
        e.ch   = c;
        e.data = m_rdata;
        e.last = m_rlast;
        e.resp = m_rresp;
        r_q.push_back(e);
    endfunction

    // Advance one cycle; transfers completing at the coming edge are scored at the negedge.
    task automatic tick();
        ar_exp_t ea;
        r_exp_t  er;
        @(negedge ap_clk);
        if (m_arvalid && m_arready) begin
            n_cmp++;
            if (ar_q.size() == 0) begin
                n_bad++;
                $display("FAIL ar_unexpected: got id=%0d addr=%h, expected no AR transfer", m_arid, m_araddr);
            end else begin
                ea = ar_q.pop_front();
                if ({m_araddr, m_arlen, m_arid} !== {ea.addr, ea.len, ea.id}) begin
                    n_bad++;
                    $display("FAIL ar_transfer: got addr=%h len=%0d id=%0d, expected addr=%h len=%0d id=%0d",
                             m_araddr, m_arlen, m_arid, ea.addr, ea.len, ea.id);
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            if (s_rvalid[c] && s_rready[c]) begin
                n_cmp++;
                r_delivered++;
                if (r_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL r_unexpected: got beat on ch%0d data=%h, expected none", c, s_rdata[31:0]);
                end else begin
                    er = r_q.pop_front();
                    if (c != er.ch || s_rvalid !== (N'(1) << c) ||
                        {s_rdata, s_rlast, s_rresp} !== {er.data, er.last, er.resp}) begin
                        n_bad++;
                        $display("FAIL r_beat: got ch%0d rvalid=%b data=%h last=%b resp=%0d, expected ch%0d data=%h last=%b resp=%0d",
                                 c, s_rvalid, s_rdata[31:0], s_rlast, s_rresp,
                                 er.ch, er.data[31:0], er.last, er.resp);
                    end
                end
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_idle();
        cache_initializing = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rid     = '0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
    endtask

    task automatic apply_reset();
        areset_n = 1'b0;
        drive_idle();
        ar_q.delete();
        r_q.delete();
        repeat (2) @(posedge ap_clk);
        #1;
        areset_n = 1'b1;
    endtask

    task automatic test_reset_init();
        areset_n = 1'b0;
        drive_idle();
        cache_initializing = 1'b1;
        s_arvalid = '1;
        m_arready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        n_cmp++;
        if ({m_arvalid, s_rvalid, s_arready, route_error, cache_setup_signal} !== {1'b0, 4'b0, 4'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got arvalid=%b rvalid=%b arready=%b route_error=%b setup=%b, expected 0 0 0 0 1",
                     m_arvalid, s_rvalid, s_arready, route_error, cache_setup_signal);
        end
        areset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (s_arready !== 4'b0000 || cache_setup_signal !== 1'b1) begin
                n_bad++;
                $display("FAIL init_block: cycle %0d got arready=%b setup=%b, expected 0000 1", i, s_arready, cache_setup_signal);
            end
            tick();
        end
        cache_initializing = 1'b0;
        #1;
        n_cmp++;
        if (s_arready !== 4'b0001) begin
            n_bad++;
            $display("FAIL first_grant: got arready=%b, expected 0001", s_arready);
        end
        push_ar(0);
        tick();
        s_arvalid = '0;
        #1;
        n_cmp++;
        if (cache_setup_signal !== 1'b0 || m_arvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL setup_follow: got setup=%b arvalid=%b, expected 0 1", cache_setup_signal, m_arvalid);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        s_arvalid = '1;
        m_arready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++;
            if (s_arready !== (N'(1) << (i % N)) || (i > 0 && m_arvalid !== 1'b1)) begin
                n_bad++;
                $display("FAIL rr_order: step %0d got arready=%b arvalid=%b, expected %b 1",
                         i, s_arready, m_arvalid, N'(1) << (i % N));
            end
            push_ar(i % N);
            tick();
        end
        s_arvalid = '0;
        tick();
        tick();
        n_cmp++;
        if (ar_q.size() != 0) begin
            n_bad++;
            $display("FAIL rr_drain: got %0d pending AR, expected 0", ar_q.size());
        end
    endtask

    task automatic test_outstanding();
        apply_reset();
        m_arready = 1'b1;
        s_rready  = '1;
        s_arvalid = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (s_arready !== 4'b0100) begin
                n_bad++;
                $display("FAIL ch2_fill: burst %0d got arready=%b, expected 0100", i, s_arready);
            end
            push_ar(2);
            tick();
        end
        s_arvalid = 4'b0110;
        #1;
        n_cmp++;
        if (s_arready !== 4'b0010) begin
            n_bad++;
            $display("FAIL ch2_limit: got arready=%b, expected 0010", s_arready);
        end
        push_ar(1);
        tick();
        s_arvalid = 4'b0100;
        m_rvalid  = 1'b1;
        m_rid     = 4'd2;
        m_rlast   = 1'b1;
        m_rdata   = {16{32'hC0DE_0002}};
        #1;
        n_cmp++;
        if (s_arready !== 4'b0000 || m_rready !== 1'b1) begin
            n_bad++;
            $display("FAIL ch2_stall: got arready=%b rready=%b, expected 0000 1", s_arready, m_rready);
        end
        push_r(2);
        tick();
        m_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (s_arready !== 4'b0000 || s_rvalid !== 4'b0100) begin
            n_bad++;
            $display("FAIL ch2_return: got arready=%b rvalid=%b, expected 0000 0100", s_arready, s_rvalid);
        end
        tick();
        n_cmp++;
        if (s_arready !== 4'b0100) begin
            n_bad++;
            $display("FAIL ch2_reopen: got arready=%b, expected 0100", s_arready);
        end
        push_ar(2);
        tick();
        s_arvalid = '0;
        tick();
        tick();
        n_cmp++;
        if (ar_q.size() != 0 || r_q.size() != 0) begin
            n_bad++;
            $display("FAIL outstanding_drain: got ar=%0d r=%0d pending, expected 0 0", ar_q.size(), r_q.size());
        end
    endtask

    task automatic test_r_backpressure();
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        int k = 0;
        int start;
        logic hold = 1'b0;
        logic accepted;
        logic [DW-1:0] hold_data = '0;
        apply_reset();
        start = r_delivered;
        for (int i = 0; i < 12; i++) begin
            s_rready = (i < 6) ? N'(pat[i] << 1) : 4'b0010;
            m_rvalid = (k < 4);
            m_rid    = 4'd1;
            m_rdata  = {16{32'hA5A5_0000 | 32'(k)}};
            m_rlast  = (k == 3);
            m_rresp  = (k == 2) ? 2'b10 : 2'b00;
            #1;
            if (hold) begin
                n_cmp++;
                if (s_rvalid !== 4'b0010 || s_rdata !== hold_data) begin
                    n_bad++;
                    $display("FAIL r_stall_hold: cycle %0d got rvalid=%b data=%h, expected 0010 data=%h",
                             i, s_rvalid, s_rdata[31:0], hold_data[31:0]);
                end
            end
            hold = 1'b0;
            accepted = m_rvalid && m_rready;
            if (accepted) push_r(1);
            if (s_rvalid[1] && !s_rready[1]) begin
                hold = 1'b1;
                hold_data = s_rdata;
            end
            tick();
            if (accepted) k++;
        end
        m_rvalid = 1'b0;
        tick();
        n_cmp++;
        if (r_delivered - start != 4 || r_q.size() != 0) begin
            n_bad++;
            $display("FAIL r_burst_count: got %0d beats (%0d pending), expected 4 (0 pending)",
                     r_delivered - start, r_q.size());
        end
    endtask

    task automatic test_route_error();
        int d0;
        apply_reset();
        s_rready = '1;
        m_rvalid = 1'b1;
        m_rid    = 4'd7;
        m_rlast  = 1'b1;
        m_rdata  = {16{32'hBAD0_0007}};
        #1;
        n_cmp++;
        if (m_rready !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_rid_accept: got rready=%b, expected 1", m_rready);
        end
        tick();
        m_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (s_rvalid !== 4'b0000 || route_error !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_rid_drop: got rvalid=%b route_error=%b, expected 0000 1", s_rvalid, route_error);
        end
        tick();
        tick();
        m_rvalid = 1'b1;
        m_rid    = 4'd0;
        m_rlast  = 1'b0;
        m_rdata  = {16{32'h600D_0000}};
        #1;
        push_r(0);
        tick();
        m_rvalid = 1'b0;
        d0 = r_delivered;
        #1;
        n_cmp++;
        if (s_rvalid !== 4'b0001) begin
            n_bad++;
            $display("FAIL good_rid_after: got rvalid=%b, expected 0001", s_rvalid);
        end
        tick();
        n_cmp++;
        if (r_delivered != d0 + 1 || route_error !== 1'b1) begin
            n_bad++;
            $display("FAIL route_error_sticky: got beats=%0d route_error=%b, expected %0d 1",
                     r_delivered, route_error, d0 + 1);
        end
    endtask

    task automatic test_init_pending();
        apply_reset();
        s_arvalid = 4'b0001;
        #1;
        push_ar(0);
        tick();
        cache_initializing = 1'b1;
        s_arvalid = 4'b0010;
        m_arready = 1'b1;
        #1;
        n_cmp++;
        if (m_arvalid !== 1'b1 || s_arready !== 4'b0000) begin
            n_bad++;
            $display("FAIL init_pending: got arvalid=%b arready=%b, expected 1 0000", m_arvalid, s_arready);
        end
        tick();
        n_cmp++;
        if (m_arvalid !== 1'b0 || ar_q.size() != 0) begin
            n_bad++;
            $display("FAIL init_pending_done: got arvalid=%b pending=%0d, expected 0 0", m_arvalid, ar_q.size());
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        m_arready = 1'b1;
        s_arvalid = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            #1;
            push_ar(2);
            tick();
        end
        s_arvalid = 4'b1000;
        #1;
        push_ar(3);
        tick();
        m_arready = 1'b0;
        s_arvalid = '0;
        m_rvalid  = 1'b1;
        m_rid     = 4'd1;
        m_rlast   = 1'b0;
        m_rdata   = {16{32'h0000_BEEF}};
        #1;
        push_r(1);
        tick();
        m_rvalid  = 1'b0;
        s_arvalid = 4'b0100;
        #1;
        n_cmp++;
        if (m_arvalid !== 1'b1 || m_arid !== 4'd3 || s_rvalid !== 4'b0010 || s_arready !== 4'b0000) begin
            n_bad++;
            $display("FAIL pre_reset_full: got arvalid=%b arid=%0d rvalid=%b arready=%b, expected 1 3 0010 0000",
                     m_arvalid, m_arid, s_rvalid, s_arready);
        end
        #2;
        areset_n = 1'b0;
        #1;
        n_cmp++;
        if (m_arvalid !== 1'b0 || s_rvalid !== 4'b0000 || s_arready !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_reset: got arvalid=%b rvalid=%b arready=%b, expected 0 0000 0000",
                     m_arvalid, s_rvalid, s_arready);
        end
        ar_q.delete();
        r_q.delete();
        @(posedge ap_clk);
        #1;
        areset_n  = 1'b1;
        s_arvalid = '1;
        m_arready = 1'b1;
        #1;
        n_cmp++;
        if (s_arready !== 4'b0001) begin
            n_bad++;
            $display("FAIL post_reset_ch0: got arready=%b, expected 0001", s_arready);
        end
        push_ar(0);
        tick();
        s_arvalid = 4'b0100;
        #1;
        n_cmp++;
        if (s_arready !== 4'b0100) begin
            n_bad++;
            $display("FAIL post_reset_counter: got arready=%b, expected 0100", s_arready);
        end
        push_ar(2);
        tick();
        s_arvalid = '0;
        tick();
        tick();
        n_cmp++;
        if (ar_q.size() != 0 || r_q.size() != 0) begin
            n_bad++;
            $display("FAIL post_reset_drain: got ar=%0d r=%0d pending, expected 0 0", ar_q.size(), r_q.size());
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            s_araddr[c*AW +: AW] = 64'hFFFF_FFFF_FFFF_FFC0 ^ (64'(c) << 8);
            s_arlen[c*8 +: 8]    = 8'(c * 3 + 1);
        end
        test_reset_init();
        test_round_robin();
        test_outstanding();
        test_r_backpressure();
        test_route_error();
        test_init_pending();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_cache_read_arbiter.md
Name: kernel_cache_read_arbiter

Overview:
- Parametrised successor to the single-port kernel cache front-end.
- Merges NUM_CHANNELS independent AXI4 read requesters onto the one read port of the system cache, using round-robin arbitration.
- Tags each request's ARID with the channel index and routes R beats back by RID.
- Bounds outstanding bursts per channel and blocks all traffic while the cache is initialising; AR and R boundaries are registered.

Parameters:
- NUM_CHANNELS, 4, number of requester channels (2..16)
- ADDR_W, 64, address width; bit ADDR_W-1 is forced to 0 toward the cache
- DATA_W, 512, R data width
- ID_W, 4, ARID/RID width; must satisfy ID_W >= clog2(NUM_CHANNELS)
- MAX_OUTSTANDING, 8, maximum in-flight bursts per channel (power of 2)

Ports:
- ap_clk  in  1  the single clock for the block
- areset_n  in  1  asynchronous, active-low reset
- cache_initializing  in  1  Initializing output of the system cache
- cache_setup_signal  out  1  registered copy of cache_initializing
- s_arvalid  in  NUM_CHANNELS  per-channel AR valid
- s_arready  out  NUM_CHANNELS  per-channel AR ready
- s_araddr  in  NUM_CHANNELS*ADDR_W  per-channel address, channel c at [c*ADDR_W +: ADDR_W]
- s_arlen  in  NUM_CHANNELS*8  per-channel burst length
- s_rvalid  out  NUM_CHANNELS  per-channel R valid (one-hot or zero)
- s_rready  in  NUM_CHANNELS  per-channel R ready
- s_rdata  out  DATA_W  shared R data
- s_rlast  out  1  shared R last
- s_rresp  out  2  shared R response
- m_arvalid / m_arready  out / in  1  AR handshake to the cache
- m_araddr  out  ADDR_W  address to the cache
- m_arlen  out  8  burst length to the cache
- m_arid  out  ID_W  ID to the cache
- m_rvalid / m_rready  in / out  1  R handshake from the cache
- m_rdata  in  DATA_W  R data from the cache
- m_rid  in  ID_W  R ID from the cache
- m_rlast  in  1  R last from the cache
- m_rresp  in  2  R response from the cache
- route_error  out  1  sticky flag: a beat arrived with RID >= NUM_CHANNELS

Behaviour:
- Reset (areset_n=0, asynchronous):
  - m_arvalid=0, s_rvalid=0, s_arready=0, route_error=0.
  - cache_setup_signal=1.
  - All outstanding counters = 0; round-robin pointer = 0.
  - Reset mid-burst discards in-flight state; no beats are replayed.
- cache_setup_signal: registered cache_initializing, 1-cycle delay.
- Grant eligibility: channel c is eligible iff s_arvalid[c]=1, its counter < MAX_OUTSTANDING, and cache_initializing=0.
- AR slot: single-entry register.
  - Grant happens when the slot is empty, or full and m_arready=1 in the same cycle.
  - Winner is the first eligible channel at or after the RR pointer, wrapping modulo NUM_CHANNELS.
  - On grant: s_arready[winner]=1 combinationally, and only for that channel.
  - The slot loads m_araddr = {1'b0, addr[ADDR_W-2:0]}, m_arlen, and m_arid = winner zero-extended.
  - The RR pointer advances to winner+1.
- AR latency: request accepted at cycle N → m_arvalid=1 at N+1.
  - m_arvalid/m_araddr/m_arlen/m_arid stay stable until m_arready=1.
  - Back-to-back grants sustain 1 burst/cycle.
- Outstanding counter per channel, width clog2(MAX_OUTSTANDING)+1:
  - +1 on that channel's s_arvalid & s_arready.
  - -1 on its R handshake with s_rlast=1.
  - Both in the same cycle: counter unchanged.
  - Never wraps; a channel is ineligible when its counter is full.
- R slot: single-entry register.
  - m_rready = ~r_full | s_rready[r_ch].
  - On an m_rvalid & m_rready beat: capture rdata/rlast/rresp and r_ch = m_rid.
  - s_rvalid[r_ch]=1 the next cycle; all other bits 0.
  - R latency 1 cycle; full throughput when s_rready stays high.
  - The slot holds stable while s_rready[r_ch]=0.
- Invalid RID (>= NUM_CHANNELS): beat is accepted (m_rready follows the empty-slot rule), dropped without presenting any s_rvalid, and route_error is set until reset.
- cache_initializing rising while the AR slot is full: the pending m_arvalid completes normally; no new grants are made.

Test Plan:
- Reset hold then release with cache_initializing=1 for 10 cycles; all s_arvalid=1 → no s_arready, cache_setup_signal=1; first grant to ch0 on the first cycle after initializing drops, m_arid=0.
- NUM_CHANNELS=4, all channels request continuously, m_arready=1 → grant order 0,1,2,3,0…; m_arvalid high every cycle; each araddr bit 63 = 0 even when input 0xFFFF_FFFF_FFFF_FFC0.
- Ch2 issues 8 single-beat bursts with no R returned → 9th request stalls (s_arready[2]=0) while ch1 is still granted; one R beat rid=2 rlast=1 → ch2 eligible again next cycle.
- Cache returns an arlen=3 burst rid=1 while s_rready[1] toggles 1,0,1,1,0,1 → exactly 4 beats in order on s_rvalid[1]; data stable during stalls; rlast on the 4th beat only.
- Beat with rid=7 (NUM_CHANNELS=4) → no s_rvalid asserted, route_error=1 thereafter; a following rid=0 beat is delivered normally.
- Assert areset_n low mid-burst with the AR and R slots full → m_arvalid, s_rvalid and counters clear immediately (asynchronously); after release, normal arbitration resumes from ch0.
